// File: rtl/digital_lock_ctrl.sv
// Keypad lock controller: code set/confirm, unlock with failed-attempt lockout,
// edge-detected key capture and an inter-digit entry timeout.
module digital_lock_ctrl #(
    parameter int unsigned PASSWORD_LENGTH = 4,
    parameter int unsigned KEY_WIDTH       = 4,
    parameter int unsigned MAX_ATTEMPTS    = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 50000000,
    parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [KEY_WIDTH-1:0]                     key,
    output logic                                     lock,
    output logic                                     error,
    output logic                                     lockout,
    output logic                                     entry_active,
    output logic [$clog2(PASSWORD_LENGTH+1)-1:0]     digits_entered,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]        fail_count
);

    localparam int unsigned DigW  = $clog2(PASSWORD_LENGTH + 1);
    localparam int unsigned FailW = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned LockW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned IdleW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned BufW  = PASSWORD_LENGTH * KEY_WIDTH;

    typedef enum logic [2:0] {
        StUnlocked, StSet, StConfirm, StCheckSet,
        StLocked, StEnter, StCheckUnlock, StLockout
    } state_e;

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_prev_q, key_prev_d;
    logic [BufW-1:0]      buf_q, buf_d, cand_q, cand_d, saved_q, saved_d;
    logic [DigW-1:0]      digits_q, digits_d;
    logic [FailW-1:0]     fail_q, fail_d;
    logic [IdleW-1:0]     idle_q, idle_d;
    logic [LockW-1:0]     lock_cnt_q, lock_cnt_d;
    logic                 lock_q, lock_d, error_q, error_d;
    logic                 lockout_q, lockout_d, entry_q, entry_d;

    logic                 press, last_digit, idle_hit;
    logic [BufW-1:0]      buf_wr;
    logic [IdleW-1:0]     idle_inc;

    always_comb begin
        press      = (|key) && !(|key_prev_q);
        last_digit = (digits_q == DigW'(PASSWORD_LENGTH - 1));
        idle_inc   = idle_q + IdleW'(1);
        idle_hit   = (TIMEOUT_CYCLES != 0) && (idle_inc == IdleW'(TIMEOUT_CYCLES));

        // Slot 0 lives in the MSBs of the entry buffer
        buf_wr = buf_q;
        for (int unsigned i = 0; i < PASSWORD_LENGTH; i++) begin
            if (digits_q == DigW'(i)) begin
                buf_wr[(PASSWORD_LENGTH-1-i)*KEY_WIDTH +: KEY_WIDTH] = key;
            end
        end

        state_d    = state_q;
        key_prev_d = key;
        buf_d      = buf_q;
        cand_d     = cand_q;
        saved_d    = saved_q;
        digits_d   = digits_q;
        fail_d     = fail_q;
        idle_d     = '0;
        lock_cnt_d = '0;
        lock_d     = lock_q;
        error_d    = error_q;
        lockout_d  = lockout_q;

        case (state_q)
            StUnlocked, StSet: begin
                if (press) begin
                    if (state_q == StUnlocked) error_d = 1'b0;
                    if (last_digit) begin
                        cand_d   = buf_wr;
                        buf_d    = '0;
                        digits_d = '0;
                        state_d  = StConfirm;
                    end else begin
                        buf_d    = buf_wr;
                        digits_d = digits_q + DigW'(1);
                        state_d  = StSet;
                    end
                end else if (state_q == StSet) begin
                    if (idle_hit) begin
                        error_d  = 1'b1;
                        buf_d    = '0;
                        cand_d   = '0;
                        digits_d = '0;
                        state_d  = StUnlocked;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
            StConfirm: begin
                if (press) begin
                    buf_d    = buf_wr;
                    digits_d = digits_q + DigW'(1);
                    if (last_digit) state_d = StCheckSet;
                end else if (idle_hit) begin
                    error_d  = 1'b1;
                    buf_d    = '0;
                    cand_d   = '0;
                    digits_d = '0;
                    state_d  = StUnlocked;
                end else begin
                    idle_d = idle_inc;
                end
            end
            StCheckSet: begin
                if (buf_q == cand_q) begin
                    saved_d = cand_q;
                    lock_d  = 1'b1;
                    state_d = StLocked;
                end else begin
                    error_d = 1'b1;
                    state_d = StUnlocked;
                end
                cand_d   = '0;
                buf_d    = '0;
                digits_d = '0;
            end
            StLocked, StEnter: begin
                if (press) begin
                    if (state_q == StLocked) error_d = 1'b0;
                    buf_d    = buf_wr;
                    digits_d = digits_q + DigW'(1);
                    state_d  = last_digit ? StCheckUnlock : StEnter;
                end else if (state_q == StEnter) begin
                    if (idle_hit) begin
                        error_d  = 1'b1;
                        buf_d    = '0;
                        digits_d = '0;
                        state_d  = StLocked;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
            StCheckUnlock: begin
                if (buf_q == saved_q) begin
                    lock_d  = 1'b0;
                    saved_d = '0;
                    fail_d  = '0;
                    state_d = StUnlocked;
                end else begin
                    error_d = 1'b1;
                    fail_d  = fail_q + FailW'(1);
                    if (fail_d == FailW'(MAX_ATTEMPTS)) begin
                        lockout_d = 1'b1;
                        state_d   = StLockout;
                    end else begin
                        state_d = StLocked;
                    end
                end
                buf_d    = '0;
                digits_d = '0;
            end
            StLockout: begin
                if (lock_cnt_q == LockW'(LOCKOUT_CYCLES - 1)) begin
                    fail_d    = '0;
                    lockout_d = 1'b0;
                    state_d   = StLocked;
                end else begin
                    lock_cnt_d = lock_cnt_q + LockW'(1);
                end
            end
            default: state_d = StUnlocked;
        endcase

        entry_d = (state_d == StSet) || (state_d == StConfirm) || (state_d == StEnter);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StUnlocked;
            key_prev_q <= '0;
            buf_q      <= '0;
            cand_q     <= '0;
            saved_q    <= '0;
            digits_q   <= '0;
            fail_q     <= '0;
            idle_q     <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            error_q    <= 1'b0;
            lockout_q  <= 1'b0;
            entry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            buf_q      <= buf_d;
            cand_q     <= cand_d;
            saved_q    <= saved_d;
            digits_q   <= digits_d;
            fail_q     <= fail_d;
            idle_q     <= idle_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            error_q    <= error_d;
            lockout_q  <= lockout_d;
            entry_q    <= entry_d;
        end
    end

    assign lock           = lock_q;
    assign error          = error_q;
    assign lockout        = lockout_q;
    assign entry_active   = entry_q;
    assign digits_entered = digits_q;
    assign fail_count     = fail_q;

endmodule

// File: doc/digital_lock_ctrl.md
# digital_lock_ctrl

Parametrised keypad lock controller for the DE1-SoC digital lock system: replaces the fixed 4-digit lock FSM with configurable code length and key width. Adds edge-detected key capture, an inter-digit entry timeout, and a failed-attempt counter with timed lockout. Sits between the debounced/synchronised push-button inputs and the lock/status indicators (LEDs, seven-segment drivers).

## Interface
- PASSWORD_LENGTH, 4: digits per code, ≥1.
- KEY_WIDTH, 4: bits per key vector and per stored digit.
- MAX_ATTEMPTS, 3: consecutive wrong unlock codes that trigger lockout, ≥1.
- LOCKOUT_CYCLES, 50000000: lockout duration in clock cycles, ≥1.
- TIMEOUT_CYCLES, 250000000: idle cycles allowed between digits during entry; 0 disables the timeout.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- key  in  KEY_WIDTH  synchronised, debounced keys, active-high.
- lock  out  1  1 = locked.
- error  out  1  last entry failed (mismatch or timeout).
- lockout  out  1  lockout in progress; keys ignored.
- entry_active  out  1  code entry in progress.
- digits_entered  out  $clog2(PASSWORD_LENGTH+1)  digits captured in the current entry.
- fail_count  out  $clog2(MAX_ATTEMPTS+1)  consecutive failed unlock attempts.

## Operation
- Press detect: key_prev registered each cycle (reset 0). press = (key != 0) && (key_prev == 0). Holding or changing keys while any key is held produces no new press. The captured digit is the full key vector, so multi-key chords are valid digits.
- Entry buffer: PASSWORD_LENGTH×KEY_WIDTH. Each press writes key at slot digits_entered (slot 0 at MSBs) and increments digits_entered.
- States:
  - UNLOCKED: press → SET with digit 0 captured; error cleared.
  - SET: on press completing PASSWORD_LENGTH digits → candidate <= buffer, buffer and count cleared, → CONFIRM.
  - CONFIRM: on press completing PASSWORD_LENGTH digits → CHECK_SET.
  - CHECK_SET: buffer == candidate → saved <= candidate, lock <= 1, → LOCKED. Otherwise error <= 1 → UNLOCKED. Candidate and buffer are cleared on either outcome.
  - LOCKED: press → ENTER with digit 0 captured; error cleared.
  - ENTER: on press completing PASSWORD_LENGTH digits → CHECK_UNLOCK.
  - CHECK_UNLOCK: match → lock <= 0, saved <= 0, fail_count <= 0, → UNLOCKED. Mismatch → error <= 1, fail_count increments. If the new count equals MAX_ATTEMPTS, → LOCKOUT; else → LOCKED. The buffer is cleared on every outcome.
  - LOCKOUT: lockout = 1. Stay for LOCKOUT_CYCLES cycles, then fail_count <= 0, lockout <= 0, → LOCKED. error stays 1.
- Presses in CHECK_SET, CHECK_UNLOCK and LOCKOUT are discarded and do not queue.
- entry_active = 1 in SET, CONFIRM and ENTER.
- Timeout: an idle counter runs in SET, CONFIRM and ENTER. It clears on every press and on state entry.
  - Reaching TIMEOUT_CYCLES in SET or CONFIRM → error <= 1, buffer/candidate/count cleared, → UNLOCKED.
  - Reaching TIMEOUT_CYCLES in ENTER → error <= 1, buffer/count cleared, → LOCKED. A timeout does not change fail_count.
  - If a press and a timeout occur in the same cycle, the press wins.
- Reset at any point, including mid-entry or mid-lockout:
  - State UNLOCKED.
  - All outputs 0.
  - saved, candidate, buffer, and the idle and lockout counters all 0.

## Timing
- All outputs are registered.
- A press is captured at the first rising edge at which key != 0 and key_prev == 0. digits_entered updates at that edge.
- Final digit captured at edge N → CHECK state during cycle N..N+1. lock/error/fail_count/lockout update at edge N+1.
- Lockout lasts exactly LOCKOUT_CYCLES cycles with lockout = 1. LOCKED is re-entered and lockout returns to 0 at the following edge.
- Timeout fires at the edge where the idle count reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after the last press or state entry.
- Counter widths: $clog2 of (limit+1). No wrap-around is reachable.

## Test plan
Bench parameters: PASSWORD_LENGTH=4, KEY_WIDTH=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=20, TIMEOUT_CYCLES=50.
- Set and lock: presses 1,2,4,8 then 1,2,4,8 → lock=1 one cycle after the 8th capture; error=0; digits_entered returns to 0.
- Confirm mismatch: 1,2,4,8 then 1,2,4,4 → lock=0, error=1. The next press clears error.
- Unlock: from locked with code 1,2,4,8, enter 1,2,4,8 → lock=0, fail_count=0.
- Lockout: from locked, three wrong codes 8,8,8,8 → fail_count 1, then 2, then 3 with lockout=1. Presses during the 20 lockout cycles have no effect on digits_entered. After lockout, fail_count=0 and lock=1; the correct code then unlocks.
- Held key and timeout: hold key=4'b0010 for 10 cycles → digits_entered=1 only. Then no press for 50 cycles → error=1, state UNLOCKED, digits_entered=0.
- Async reset mid-ENTER after 2 digits → all outputs 0 immediately. Then a 4-digit set/confirm works normally.
